// File: rtl/gate_tester_if.sv
// gate_tester_if: bundles the run-control, gate-drive and verdict signals of
// gate_tester. The slave modport is the tester; the master modport is the
// side that requests runs and hosts the gate under test (it supplies y).
interface gate_tester_if #(
    parameter int CNT_W = 8
);
    logic             start;
    logic             a;
    logic             b;
    logic             y;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] err_count;
    logic [3:0]       fail_vec;

    modport master (
        output start, y,
        input  a, b, busy, done, pass, err_count, fail_vec
    );

    modport slave (
        input  start, y,
        output a, b, busy, done, pass, err_count, fail_vec
    );
endinterface

// File: rtl/gate_tester.sv
// gate_tester: drives a 2-input gate through all four {a,b} combinations,
// waits SETTLE_CYCLES, samples y and checks it against TRUTH (bit index {a,b}).
// Repeats the sweep PASSES times, then reports pass, err_count (saturating)
// and sticky per-combination fail_vec.
// Optional build macro GATE_TESTER_STOP_ON_FAIL_EN: the first mismatch ends
// the run immediately.
module gate_tester #(
    parameter logic [3:0] TRUTH         = 4'b1110,
    parameter int         SETTLE_CYCLES = 2,
    parameter int         PASSES        = 1,
    parameter int         CNT_W         = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    gate_tester_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    localparam logic [7:0] SETTLE_LD = 8'(SETTLE_CYCLES);
    localparam logic [7:0] LAST_PASS = 8'(PASSES - 1);

    state_t           state_q, state_d;
    logic [7:0]       settle_q, settle_d;
    logic [1:0]       idx_q, idx_d;
    logic [7:0]       pidx_q, pidx_d;
    logic [1:0]       ab_q, ab_d;
    logic [CNT_W-1:0] err_q, err_d;
    logic [3:0]       fail_q, fail_d;
    logic             pass_q, pass_d;
    logic             mism;
    logic             last_vec;
    logic             finish;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) begin
            return v;
        end
        return v + CNT_W'(1);
    endfunction

    // State and datapath registers; reset returns every output to zero.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            settle_q <= '0;
            idx_q    <= '0;
            pidx_q   <= '0;
            ab_q     <= '0;
            err_q    <= '0;
            fail_q   <= '0;
            pass_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            idx_q    <= idx_d;
            pidx_q   <= pidx_d;
            ab_q     <= ab_d;
            err_q    <= err_d;
            fail_q   <= fail_d;
            pass_q   <= pass_d;
        end
    end

    // Next-state logic: settle countdown, sample/compare, vector and pass sequencing.
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        idx_d    = idx_q;
        pidx_d   = pidx_q;
        ab_d     = ab_q;
        err_d    = err_q;
        fail_d   = fail_q;
        pass_d   = pass_q;
        mism     = 1'b0;
        last_vec = 1'b0;
        finish   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d  = S_SETTLE;
                    ab_d     = 2'b00;
                    idx_d    = 2'd0;
                    pidx_d   = 8'd0;
                    err_d    = '0;
                    fail_d   = 4'b0000;
                    pass_d   = 1'b0;
                    settle_d = SETTLE_LD;
                end
            end

            S_SETTLE: begin
                // Leaving on the edge where the counter reaches zero keeps
                // each vector at exactly SETTLE_CYCLES+1 cycles.
                settle_d = settle_q - 8'd1;
                if (settle_q == 8'd1) begin
                    state_d = S_SAMPLE;
                end
            end

            S_SAMPLE: begin
                mism     = (bus.y != TRUTH[idx_q]);
                last_vec = (idx_q == 2'd3) && (pidx_q == LAST_PASS);
                if (mism) begin
                    fail_d[idx_q] = 1'b1;
                    err_d         = sat_inc(err_q);
                end
`ifdef GATE_TESTER_STOP_ON_FAIL_EN
                finish = last_vec | mism;
`else
                finish = last_vec;
`endif
                if (finish) begin
                    state_d = S_DONE;
                    // Verdict includes this final compare.
                    pass_d  = (err_d == '0);
                end else begin
                    state_d  = S_SETTLE;
                    idx_d    = idx_q + 2'd1;
                    ab_d     = idx_q + 2'd1;
                    settle_d = SETTLE_LD;
                    if (idx_q == 2'd3) begin
                        pidx_d = pidx_q + 8'd1;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
                ab_d    = 2'b00;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign bus.a         = ab_q[1];
    assign bus.b         = ab_q[0];
    assign bus.busy      = (state_q == S_SETTLE) || (state_q == S_SAMPLE);
    assign bus.done      = (state_q == S_DONE);
    assign bus.pass      = pass_q;
    assign bus.err_count = err_q;
    assign bus.fail_vec  = fail_q;

endmodule
